// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands LSB-first, one bit per
// clock, through a 1-bit full adder made of two half-adder cells and a stored carry.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] sa, sb, acc;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             p, g1, s, g2, carry_nxt;
  logic [WIDTH-1:0] acc_nxt;
  logic             accept, step, last;

  // Half-adder cell: returns {carry, sum}.
  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  // Full adder from two half adders; the shifted form of acc also covers WIDTH=1.
  always_comb begin
    {g1, p}   = half_add(sa[0], sb[0]);
    {g2, s}   = half_add(p, carry);
    carry_nxt = g1 | g2;
    acc_nxt   = (acc >> 1) | (WIDTH'(s) << (WIDTH - 1));
  end

  assign accept = (state == IDLE) && start;
  assign step   = (state == RUN);
  assign last   = step && (cnt == LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == RUN);
      done  <= (state_nxt == DONE);
    end
  end

  // Operand shifters, carry, partial-sum accumulator and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa    <= '0;
      sb    <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      sa    <= a;
      sb    <= b;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (step) begin
      sa    <= sa >> 1;
      sb    <= sb >> 1;
      acc   <= acc_nxt;
      carry <= carry_nxt;
      cnt   <= cnt + CNT_W'(1);
    end
  end

  // Result registers only move on the final bit, so they hold across a new RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
      co  <= 1'b0;
    end else if (last) begin
      sum <= acc_nxt;
      co  <= carry_nxt;
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start8, busy8, done8, co8;
  logic [7:0] a8, b8, sum8;
  logic       start1, busy1, done1, co1;
  logic [0:0] a1, b1, sum1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] prev_sum8;
  logic       prev_co8;
  logic       prev_sum1, prev_co1;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .co(co8)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .co(co1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    logic       co;
    string      name;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic cur_busy(input bit w1);
    return w1 ? busy1 : busy8;
  endfunction
  function automatic logic cur_done(input bit w1);
    return w1 ? done1 : done8;
  endfunction
  function automatic logic cur_co(input bit w1);
    return w1 ? co1 : co8;
  endfunction
  function automatic logic [7:0] cur_sum(input bit w1);
    return w1 ? {7'd0, sum1} : sum8;
  endfunction

  // One full operation: accept, busy length, result hold during RUN, done pulse, result.
  task automatic do_op(input bit w1, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] esum, input logic eco, input string name);
    int n;
    bit hold_ok;
    logic [7:0] ps;
    logic pc;
    ps = w1 ? {7'd0, prev_sum1} : prev_sum8;
    pc = w1 ? prev_co1 : prev_co8;
    if (w1) begin
      start1 = 1'b1; a1 = a[0:0]; b1 = b[0:0];
    end else begin
      start8 = 1'b1; a8 = a; b8 = b;
    end
    tick;
    start1 = 1'b0;
    start8 = 1'b0;
    if (w1) begin
      a1 = ~a[0:0]; b1 = ~b[0:0];
    end else begin
      a8 = ~a; b8 = ~b;
    end
    n = 0;
    hold_ok = 1'b1;
    while (cur_busy(w1) && n < 40) begin
      n++;
      if (cur_sum(w1) !== ps || cur_co(w1) !== pc || cur_done(w1) !== 1'b0) hold_ok = 1'b0;
      tick;
    end
    check({name, " busy_cycles"}, n, w1 ? 1 : 8);
    check({name, " hold_in_run"}, hold_ok, 1'b1);
    check({name, " done"}, {cur_busy(w1), cur_done(w1)}, 2'b01);
    check({name, " sum"}, cur_sum(w1), esum);
    check({name, " co"}, cur_co(w1), eco);
    tick;
    check({name, " done_one_cycle"}, {cur_busy(w1), cur_done(w1)}, 2'b00);
    if (w1) begin
      prev_sum1 = esum[0]; prev_co1 = eco;
    end else begin
      prev_sum8 = esum; prev_co8 = eco;
    end
  endtask

  initial begin
    int last_done, ndone, run_idx;
    bit seen;

    vecs[0] = '{8'h5A, 8'h3C, 8'h96, 1'b0, "5a+3c"};
    vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1, "ff+01"};
    vecs[2] = '{8'hFF, 8'hFF, 8'hFE, 1'b1, "ff+ff"};
    vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0, "00+00"};
    vecs[4] = '{8'h12, 8'h34, 8'h46, 1'b0, "12+34"};
    vecs[5] = '{8'h80, 8'h80, 8'h00, 1'b1, "80+80"};
    vecs[6] = '{8'hA5, 8'h5B, 8'h00, 1'b1, "a5+5b"};

    rst_n = 1'b0;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
    prev_sum8 = 8'h00; prev_co8 = 1'b0; prev_sum1 = 1'b0; prev_co1 = 1'b0;
    repeat (2) tick;
    check("reset w8 outputs", {busy8, done8, sum8, co8}, 11'd0);
    check("reset w1 outputs", {busy1, done1, sum1, co1}, 4'd0);
    rst_n = 1'b1;
    tick;

    for (int i = 0; i < 7; i++)
      do_op(1'b0, vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].co, vecs[i].name);

    // start held high: one accept per 10 cycles, operands scrambled mid-RUN
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h20;
    last_done = -1; ndone = 0; run_idx = 0;
    for (int c = 0; c < 45; c++) begin
      tick;
      if (busy8) begin
        run_idx++;
        if (run_idx >= 2 && run_idx <= 5) begin
          a8 = 8'hFF; b8 = 8'hFF;
        end else begin
          a8 = 8'h10; b8 = 8'h20;
        end
      end else begin
        run_idx = 0; a8 = 8'h10; b8 = 8'h20;
      end
      if (done8) begin
        check("hold_start sum", sum8, 8'h30);
        check("hold_start co", co8, 1'b0);
        if (last_done >= 0) check("hold_start period", c - last_done, 10);
        last_done = c;
        ndone++;
      end
    end
    start8 = 1'b0;
    check("hold_start op count", ndone, 4);
    repeat (12) tick;
    check("hold_start drained", {busy8, done8, sum8, co8}, {2'b00, 8'h30, 1'b0});
    prev_sum8 = 8'h30; prev_co8 = 1'b0;

    // asynchronous reset during RUN cycle 4
    do_op(1'b0, 8'hFF, 8'hFF, 8'hFE, 1'b1, "pre_reset ff+ff");
    start8 = 1'b1; a8 = 8'h33; b8 = 8'h44;
    tick;
    start8 = 1'b0;
    repeat (3) tick;
    #2 rst_n = 1'b0;
    #1;
    check("mid_run reset outputs", {busy8, done8, sum8, co8}, 11'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      tick;
      if (busy8 || done8) seen = 1'b1;
    end
    check("no done after reset", seen, 1'b0);
    prev_sum8 = 8'h00; prev_co8 = 1'b0;
    do_op(1'b0, 8'h01, 8'h02, 8'h03, 1'b0, "post_reset 01+02");

    // WIDTH=1 instance
    do_op(1'b1, 8'h01, 8'h01, 8'h00, 1'b1, "w1 1+1");
    do_op(1'b1, 8'h01, 8'h00, 8'h01, 1'b0, "w1 1+0");
    do_op(1'b1, 8'h00, 8'h00, 8'h00, 1'b0, "w1 0+0");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
